// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard / redirect controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JAL = 2'b10;
  localparam logic [1:0] PC_SEL_JR  = 2'b11;

  localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, EX-resolved
// redirects with multi-cycle IF/ID bubbles, and load-use interlock.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ifid_rs,
  input  logic [3:0]       ifid_rt,
  input  logic             ifid_use_rs,
  input  logic             ifid_use_rt,
  input  logic             idex_lw,
  input  logic [3:0]       idex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_jal,
  input  logic             ex_jr,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BCNT_W = (REDIRECT_BUBBLES < 2) ? 1 : $clog2(REDIRECT_BUBBLES);
  localparam logic [BCNT_W-1:0] BUBBLE_RELOAD = BCNT_W'(REDIRECT_BUBBLES - 1);

  state_e            state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              redirect;
  logic              load_use;
  logic              stall_en;
  logic              flush_en;

  assign redirect = ex_jr | ex_jal | ex_branch_taken;

  assign load_use = idex_lw && (idex_rd != REG_ZERO) &&
                    ((ifid_use_rs && (ifid_rs == idex_rd)) ||
                     (ifid_use_rt && (ifid_rt == idex_rd)));

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    flush_en    = 1'b0;

    if (!rst_n) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      // A frozen pipe must not lose outstanding redirect bubbles.
      if (state_q != ST_FLUSH) begin
        state_d = ST_MEM_WAIT;
      end
    end else if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_en   = 1'b1;
      if (ex_jr) begin
        pc_sel = PC_SEL_JR;
      end else if (ex_jal) begin
        pc_sel = PC_SEL_JAL;
      end else begin
        pc_sel = PC_SEL_BR;
      end
      if (REDIRECT_BUBBLES > 1) begin
        state_d = ST_FLUSH;
        bcnt_d  = BUBBLE_RELOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_FLUSH) begin
      ifid_flush = 1'b1;
      if (bcnt_q <= BCNT_W'(1)) begin
        state_d = ST_RUN;
        bcnt_d  = '0;
      end else begin
        bcnt_d  = bcnt_q - 1'b1;
      end
    end else begin
      state_d = ST_RUN;
      if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  assign stall_en = pc_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_en),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: single-bubble controller for the vector table, a 3-bubble
// controller with 3-bit counters for flush sequencing and saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ifid_rs = '0, ifid_rt = '0, idex_rd = '0;
  logic       ifid_use_rs = 1'b0, ifid_use_rt = 1'b0, idex_lw = 1'b0;
  logic       ex_branch_taken = 1'b0, ex_jal = 1'b0, ex_jr = 1'b0, dmem_busy = 1'b0;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_stall, a_idex_flush, a_exmem_stall;
  logic [1:0]  a_pc_sel;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_stall, b_idex_flush, b_exmem_stall;
  logic [1:0]  b_pc_sel;
  logic [2:0]  b_stall_cnt, b_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .idex_lw(idex_lw),
    .idex_rd(idex_rd), .ex_branch_taken(ex_branch_taken), .ex_jal(ex_jal),
    .ex_jr(ex_jr), .dmem_busy(dmem_busy), .pc_stall(a_pc_stall),
    .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush), .idex_stall(a_idex_stall),
    .idex_flush(a_idex_flush), .exmem_stall(a_exmem_stall), .pc_sel(a_pc_sel),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(3), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt), .idex_lw(idex_lw),
    .idex_rd(idex_rd), .ex_branch_taken(ex_branch_taken), .ex_jal(ex_jal),
    .ex_jr(ex_jr), .dmem_busy(dmem_busy), .pc_stall(b_pc_stall),
    .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush), .idex_stall(b_idex_stall),
    .idex_flush(b_idex_flush), .exmem_stall(b_exmem_stall), .pc_sel(b_pc_sel),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // Control word: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, pc_sel}
  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b1100_1000;
  localparam logic [7:0] C_BUSY  = 8'b1101_0100;
  localparam logic [7:0] C_BR    = 8'b0010_1001;
  localparam logic [7:0] C_JAL   = 8'b0010_1010;
  localparam logic [7:0] C_JR    = 8'b0010_1011;
  localparam logic [7:0] C_RESET = 8'b0010_1000;

  typedef struct {
    logic [3:0] rs, rt, rd;
    logic       use_rs, use_rt, lw, br, jal, jr, busy;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [3:0] rs, input logic [3:0] rt, input logic use_rs,
                              input logic use_rt, input logic lw, input logic [3:0] rd,
                              input logic br, input logic jal, input logic jr,
                              input logic busy, input logic [7:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt; v.lw = lw; v.rd = rd;
    v.br = br; v.jal = jal; v.jr = jr; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] a_ctl();
    return {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_stall, a_idex_flush, a_exmem_stall, a_pc_sel};
  endfunction

  function automatic logic [7:0] b_ctl();
    return {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_stall, b_idex_flush, b_exmem_stall, b_pc_sel};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    ifid_rs = v.rs; ifid_rt = v.rt; ifid_use_rs = v.use_rs; ifid_use_rt = v.use_rt;
    idex_lw = v.lw; idex_rd = v.rd; ex_branch_taken = v.br; ex_jal = v.jal;
    ex_jr = v.jr; dmem_busy = v.busy;
  endtask

  task automatic idle();
    set_in(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(); rst_n = 1'b0; idle();
    step(); rst_n = 1'b1;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;

    vecs[0]  = mk(4'd3, 4'd0, 1, 0, 1, 4'd3, 0, 0, 0, 0, C_LU);
    vecs[1]  = mk(4'd0, 4'd0, 1, 0, 1, 4'd0, 0, 0, 0, 0, C_IDLE);
    vecs[2]  = mk(4'd1, 4'd5, 0, 1, 1, 4'd5, 0, 0, 0, 0, C_LU);
    vecs[3]  = mk(4'd1, 4'd5, 1, 0, 1, 4'd5, 0, 0, 0, 0, C_IDLE);
    vecs[4]  = mk(4'd5, 4'd0, 1, 0, 0, 4'd5, 0, 0, 0, 0, C_IDLE);
    vecs[5]  = mk(4'd6, 4'd8, 1, 1, 1, 4'd7, 0, 0, 0, 0, C_IDLE);
    vecs[6]  = mk(4'd3, 4'd0, 1, 0, 1, 4'd3, 1, 0, 0, 0, C_BR);
    vecs[7]  = mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, 0, C_JAL);
    vecs[8]  = mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 1, 1, 0, C_JR);
    vecs[9]  = mk(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 1, 0, 0, C_JAL);
    vecs[10] = mk(4'd3, 4'd0, 1, 0, 1, 4'd3, 1, 0, 0, 1, C_BUSY);
    vecs[11] = mk(4'd0, 4'd0, 0, 1, 1, 4'd0, 0, 0, 0, 0, C_IDLE);
    vecs[12] = mk(4'd9, 4'd9, 1, 1, 1, 4'd9, 0, 0, 0, 0, C_LU);

    // Reset state
    idle();
    step(); #1;
    chk("reset_ctl", a_ctl(), C_RESET);
    chk("reset_ctl3", b_ctl(), C_RESET);
    chk("reset_stall_cnt", a_stall_cnt, 0);
    chk("reset_flush_cnt", a_flush_cnt, 0);
    rst_n = 1'b1;

    // Vector table against the single-bubble controller
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      set_in(vecs[i]);
      #1;
      $display("vec %0d: ctl=%b exp=%b", i, a_ctl(), vecs[i].exp);
      chk($sformatf("vec%0d_ctl", i), a_ctl(), vecs[i].exp);
      if (vecs[i].exp[7]) exp_stall++;
      if (vecs[i].exp[1:0] != 2'b00) exp_flush++;
    end
    step(); idle(); #1;
    chk("table_stall_cnt", a_stall_cnt, exp_stall);
    chk("table_flush_cnt", a_flush_cnt, exp_flush);

    // Load-use lasts one cycle once ID/EX holds the bubble
    do_reset();
    set_in(vecs[0]); #1;
    $display("seq load_use: ctl=%b", a_ctl());
    chk("lu_stall", a_ctl(), C_LU);
    step(); idex_lw = 1'b0; #1;
    chk("lu_free", a_ctl(), C_IDLE);
    chk("lu_stall_cnt", a_stall_cnt, 1);

    // Memory busy with a held jal: 4 frozen cycles then the redirect
    do_reset();
    dmem_busy = 1'b1; ex_jal = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) step();
      #1;
      $display("seq busy cycle %0d: ctl=%b", c, a_ctl());
      chk($sformatf("busy_c%0d", c), a_ctl(), C_BUSY);
    end
    step(); dmem_busy = 1'b0; #1;
    chk("busy_release_jal", a_ctl(), C_JAL);
    chk("busy_stall_cnt", a_stall_cnt, 4);
    step(); idle(); #1;
    chk("busy_flush_cnt", a_flush_cnt, 1);
    chk("busy_after_idle", a_ctl(), C_IDLE);

    // Three-bubble controller: jr, then branch restarts the count, load-use ignored in FLUSH
    do_reset();
    ex_jr = 1'b1; #1;
    chk("b3_jr", b_ctl(), C_JR);
    step(); ex_jr = 1'b0; ex_branch_taken = 1'b1; #1;
    chk("b3_restart_br", b_ctl(), C_BR);
    step(); ex_branch_taken = 1'b0;
    ifid_rs = 4'd4; ifid_use_rs = 1'b1; idex_lw = 1'b1; idex_rd = 4'd4; #1;
    chk("b3_flush1", b_ctl() & 8'b1110_0011, 8'b0010_0000);
    step(); #1;
    chk("b3_flush2", b_ctl() & 8'b1110_0011, 8'b0010_0000);
    step(); #1;
    $display("seq b3 back to run: ctl=%b", b_ctl());
    chk("b3_run_lu", b_ctl(), C_LU);
    chk("b3_flush_cnt", b_flush_cnt, 2);

    // Reset in the middle of a flush sequence
    do_reset();
    ex_jr = 1'b1; #1;
    chk("rst_mid_jr", b_ctl(), C_JR);
    step(); ex_jr = 1'b0; rst_n = 1'b0; #1;
    chk("rst_mid_ctl", b_ctl(), C_RESET);
    chk("rst_mid_flush_cnt", b_flush_cnt, 0);
    step(); rst_n = 1'b1; #1;
    chk("rst_mid_release", b_ctl(), C_IDLE);
    step(); #1;
    chk("rst_mid_release2", b_ctl(), C_IDLE);

    // Saturation of the 3-bit stall counter
    do_reset();
    dmem_busy = 1'b1;
    for (int c = 0; c < 9; c++) step();
    idle(); #1;
    $display("seq saturate: stall_cnt3=%0d stall_cnt16=%0d", b_stall_cnt, a_stall_cnt);
    chk("sat_stall_cnt3", b_stall_cnt, 7);
    chk("sat_stall_cnt16", a_stall_cnt, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
